// File: rtl/intercal_alu_seq.sv
// ============================================================================
// intercal_alu_seq : handshaked INTERCAL ALU (unary/mingle one-shot, select
// iterated one bit per cycle).  Rev 1.0
// ============================================================================
`default_nettype none

module intercal_alu_seq #(
  parameter  int W = 32,
  localparam int H = W / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic         half,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f,
  output logic         err,
  output logic         busy
);

  localparam int         CW     = $clog2(W);
  localparam logic [2:0] OP_SEL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            half_q, half_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    f_q, f_d;
  logic            err_q, err_d;

  logic [W-1:0]    rot_w, mg_w, res_w, step_w;
  logic [H-1:0]    ah_w, bh_w;
  logic [CW-1:0]   hi_idx_w;

  // Single-cycle operators, evaluated on the operands being accepted.
  always_comb begin
    rot_w = half ? {a[H], a[W-1:H+1], a[0], a[H-1:1]} : {a[0], a[W-1:1]};
    ah_w  = half ? a[W-1:H] : a[H-1:0];
    bh_w  = half ? b[W-1:H] : b[H-1:0];
    mg_w  = '0;
    for (int k = 0; k < H; k++) begin
      mg_w[2*k+1] = ah_w[k];
      mg_w[2*k]   = bh_w[k];
    end
    case (op)
      3'd0:    res_w = a;
      3'd1:    res_w = b;
      3'd2:    res_w = rot_w & a;
      3'd3:    res_w = rot_w | a;
      3'd4:    res_w = rot_w ^ a;
      3'd5:    res_w = mg_w;
      default: res_w = '0;
    endcase
  end

  // One select step; in half mode both halves advance on the same count.
  always_comb begin
    hi_idx_w = CW'(H) + cnt_q;
    if (half_q) begin
      step_w[H-1:0] = b_q[cnt_q]    ? {acc_q[H-2:0], a_q[cnt_q]}    : acc_q[H-1:0];
      step_w[W-1:H] = b_q[hi_idx_w] ? {acc_q[W-2:H], a_q[hi_idx_w]} : acc_q[W-1:H];
    end else begin
      step_w = b_q[cnt_q] ? {acc_q[W-2:0], a_q[cnt_q]} : acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    f_d     = f_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          half_d = half;
          if (op == OP_SEL) begin
            cnt_d   = half ? CW'(H - 1) : CW'(W - 1);
            acc_d   = '0;
            err_d   = 1'b0;
            state_d = S_BUSY;
          end else begin
            f_d     = res_w;
            err_d   = (op == OP_RSV);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_w;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          f_d     = step_w;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign f         = f_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_intercal_alu_seq.sv
// ============================================================================
// tb_intercal_alu_seq : directed self-checking bench for intercal_alu_seq
// (W=32 main instance, W=8 small instance).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_intercal_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, half, out_valid, out_ready, err, busy;
  logic [2:0]  op;
  logic [31:0] a, b, f;

  logic        in_valid8, in_ready8, half8, out_valid8, out_ready8, err8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, f8;

  intercal_alu_seq #(.W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .half(half), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .err(err), .busy(busy)
  );

  intercal_alu_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .half(half8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .f(f8), .err(err8), .busy(busy8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the result, then hand it off.
  task automatic run(input logic [2:0] t_op, input logic t_half,
                     input logic [31:0] t_a, input logic [31:0] t_b,
                     output logic [31:0] fo, output logic eo,
                     output int lat, output int bcnt);
    op = t_op; half = t_half; a = t_a; b = t_b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    fo = f; eo = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] fr;
  logic        er;
  int          lat, bcnt;
  logic        seen;
  int          n8;

  initial begin
    rst = 1'b1;
    in_valid = 0; op = 0; half = 0; a = 0; b = 0; out_ready = 0;
    in_valid8 = 0; op8 = 0; half8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_f", f, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run(3'd2, 1'b0, 32'h0000_0003, 32'h0, fr, er, lat, bcnt);
    check_val("and_full_f", fr, 32'h0000_0001);
    check_val("and_full_err", {31'd0, er}, 32'd0);
    check_val("and_full_lat", lat, 32'd1);

    run(3'd2, 1'b1, 32'h0003_0003, 32'h0, fr, er, lat, bcnt);
    check_val("and_half_f", fr, 32'h0001_0001);

    run(3'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, fr, er, lat, bcnt);
    check_val("pass_a_f", fr, 32'hDEAD_BEEF);
    run(3'd1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, fr, er, lat, bcnt);
    check_val("pass_b_f", fr, 32'h1234_5678);

    run(3'd5, 1'b0, 32'h0000_FFFF, 32'h0, fr, er, lat, bcnt);
    check_val("mingle_lo_f", fr, 32'hAAAA_AAAA);
    run(3'd5, 1'b1, 32'h0000_FFFF, 32'h0, fr, er, lat, bcnt);
    check_val("mingle_hi0_f", fr, 32'h0000_0000);
    run(3'd5, 1'b1, 32'hFFFF_0000, 32'h0, fr, er, lat, bcnt);
    check_val("mingle_hi_f", fr, 32'hAAAA_AAAA);

    run(3'd6, 1'b0, 32'h1234_5678, 32'h0000_FFFF, fr, er, lat, bcnt);
    check_val("sel_full_f", fr, 32'h0000_5678);
    check_val("sel_full_lat", lat, 32'd33);
    check_val("sel_full_busy", bcnt, 32'd32);
    check_val("sel_full_err", {31'd0, er}, 32'd0);

    run(3'd6, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, fr, er, lat, bcnt);
    check_val("sel_ends_f", fr, 32'h0000_0003);

    run(3'd6, 1'b1, 32'hFFFF_FFFF, 32'h00F0_000F, fr, er, lat, bcnt);
    check_val("sel_half_f", fr, 32'h000F_000F);
    check_val("sel_half_lat", lat, 32'd17);

    run(3'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, fr, er, lat, bcnt);
    check_val("rsv_f", fr, 32'h0);
    check_val("rsv_err", {31'd0, er}, 32'd1);

    // Backpressure: OR of 0x1 with its rotation, held for 5 cycles.
    op = 3'd3; half = 1'b0; a = 32'h0000_0001; b = 32'h0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 3'd0; a = 32'h5555_5555;
    check_val("bp_valid0", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_f", f, 32'h8000_0001);
      check_val("bp_err", {31'd0, err}, 32'd0);
      check_val("bp_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_val("bp_no_new", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a select.
    op = 3'd6; half = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_val("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("mid_rst_no_result", {31'd0, seen}, 32'd0);

    // W=8 instance.
    op8 = 3'd4; half8 = 1'b0; a8 = 8'h01; b8 = 8'h00; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check_val("w8_xor_valid", {31'd0, out_valid8}, 32'd1);
    check_val("w8_xor_f", {24'd0, f8}, 32'h81);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;

    op8 = 3'd6; half8 = 1'b1; a8 = 8'hFF; b8 = 8'h36; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n8 = 1;
    while (!out_valid8 && n8 < 50) begin
      @(posedge clk); #1;
      n8++;
    end
    check_val("w8_sel_half_f", {24'd0, f8}, 32'h33);
    check_val("w8_sel_half_lat", n8, 32'd5);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check_val("w8_idle", {31'd0, in_ready8}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intercal_alu_seq.md
# intercal_alu_seq

Parametrised, handshaked successor of the team's combinational INTERCAL ALU. It executes one INTERCAL operator per transaction on W-bit operands:
- pass-through;
- unary AND / OR / XOR, in full-width or per-half form;
- mingle;
- select, computed iteratively one bit per cycle.

It sits between the interpreter's operand fetch and writeback as a valid/ready slave on the input side and a valid/ready master on the output side.

## Interface
Parameters:
- W, 32, operand/result width; even, ≥4.
- H, W/2, half width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  3  0 pass a, 1 pass b, 2 unary AND, 3 unary OR, 4 unary XOR, 5 mingle, 6 select, 7 reserved.
- half  in  1  0 = full-width form (16→32-bit analogue), 1 = per-half form / high-half mingle.
- a  in  W  first operand.
- b  in  W  second operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  W  result, registered.
- err  out  1  result came from reserved op; registered alongside f.
- busy  out  1  select iteration in progress.

## Operation
- Request accepted when in_valid && in_ready; op/half/a/b captured into internal registers at that edge.
- Unary op X ∈ {AND, OR, XOR}:
  - half=0: f = rotr1(a) X a over W bits.
  - half=1: each H-bit half is rotated right by 1 within itself, then combined with X.
- Mingle: source halves are a[H-1:0], b[H-1:0] when half=0, and a[W-1:H], b[W-1:H] when half=1.
  - f[2k+1] = a-half[k], f[2k] = b-half[k], for k = 0..H-1.
- Select, half=0:
  - Gathers a[i] for every i with b[i]=1, order preserved, packed into LSBs; upper bits 0.
  - Iterative: acc←0; for i = W-1 down to 0, one step per cycle: if b[i] then acc ← {acc[W-2:0], a[i]}.
- Select, half=1: the two H-bit halves are selected independently, in parallel over H steps; f = {selH, selL}.
- Reserved op 7: f = 0, err = 1. All other ops: err = 0.
- States:
  - IDLE: in_ready=1. On accept, go to BUSY if op=6, else go to DONE with f computed combinationally from the captured operands.
  - BUSY: busy=1, in_ready=0. Step counter runs N−1 down to 0, with N = W (half=0) or H (half=1). After the count-0 step, load f from acc and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, return to IDLE.
- f and err hold their value while out_valid && !out_ready. After handoff, f keeps its last value; it is don't-care while out_valid=0.
- in_valid while in_ready=0 is ignored; the requester must hold it.

## Timing
- Reset values: out_valid=0, f=0, err=0, busy=0, state IDLE. in_ready=1 from the first cycle after rst deasserts.
- Non-select latency: accept at edge t → out_valid=1 after edge t+1.
- Select latency: accept at edge t → out_valid after edge t+N+1, i.e. 33 cycles at W=32 full, 17 at half=1.
- Maximum throughput: one non-select result every 2 cycles with out_ready held high (IDLE→DONE→IDLE).
- Reset mid-BUSY or mid-DONE: immediate return to IDLE. Partial result and pending output are discarded; no out_valid pulse is produced.
- The step counter is ⌈log2 W⌉ bits. No wrap occurs because the counter is reloaded on every accept.
- Result depends only on the captured operands. Changing a/b/op during BUSY has no effect.

## Test plan
- W=32, op=2, half=0, a=0x0000_0003 → f=0x0000_0001, err=0; out_valid exactly 1 cycle after accept.
- W=32, op=5, half=0, a=0x0000_FFFF, b=0 → f=0xAAAA_AAAA. Same operands with half=1 → f=0x0000_0000. Then a=0xFFFF_0000, b=0, half=1 → f=0xAAAA_AAAA.
- W=32, op=6, half=0:
  - a=0x1234_5678, b=0x0000_FFFF → f=0x0000_5678 after 33 cycles, busy high 32 cycles.
  - a=0xFFFF_FFFF, b=0x8000_0001 → f=0x0000_0003.
- W=32, op=6, half=1, a=0xFFFF_FFFF, b=0x00F0_000F → f=0x000F_000F after 17 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → f, err, out_valid stable, in_ready=0, new in_valid ignored. Assert out_ready → IDLE next cycle.
- Reset and parameters:
  - Assert rst on cycle 10 of a select → next cycle out_valid=0, busy=0, in_ready=1, and no result ever emitted.
  - op=7 → f=0, err=1.
  - W=8, op=4, half=0, a=0x01 → f=0x81.
